// File: rtl/dsp_seq_pkg.sv
// Shared types and widths for the DSP operation sequencer.
package dsp_seq_pkg;

  localparam int A_W   = 18;
  localparam int C_W   = 48;
  localparam int OPM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [C_W-1:0] p;
    logic           carryout;
  } dsp_res_t;

endpackage

// File: rtl/dsp_seq_fifo.sv
// Result FIFO for the DSP sequencer; overflow is prevented upstream by issue credits.
module dsp_seq_fifo
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  dsp_res_t               push_data,
  input  logic                   pop,
  output dsp_res_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  dsp_res_t      mem_q [DEPTH];
  dsp_res_t      mem_d [DEPTH];
  logic          pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Pointers are power-of-two wide, so they wrap modulo DEPTH for free.
    case ({push, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/dsp_op_sequencer.sv
// Command-side DSP driver: issues ops, tracks them through the DSP pipe, returns results in order.
// Optional performance counters are enabled with `define DSP_SEQ_PERF_EN.
//
// Handshakes: a beat transfers on a rising edge where valid && ready; valid must not depend on
// ready, and ready here depends only on registered state (no combinational path from cmd_valid).
module dsp_op_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPM_W-1:0] cmd_opmode,
  input  logic [A_W-1:0]   cmd_a,
  input  logic [A_W-1:0]   cmd_b,
  input  logic [A_W-1:0]   cmd_d,
  input  logic [C_W-1:0]   cmd_c,
  input  logic             cmd_carryin,
  input  logic             flush,
  output logic [A_W-1:0]   dsp_a,
  output logic [A_W-1:0]   dsp_b,
  output logic [A_W-1:0]   dsp_d,
  output logic [C_W-1:0]   dsp_c,
  output logic [OPM_W-1:0] dsp_opmode,
  output logic             dsp_carryin,
  input  logic [C_W-1:0]   dsp_p,
  input  logic             dsp_carryout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [C_W-1:0]   res_p,
  output logic             res_carryout,
  output logic             busy
`ifdef DSP_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 4;

  seq_state_e       state_q, state_d;
  logic [LATENCY-1:0] pipe_q, pipe_d;
  logic             live_q, live_d;
  logic [A_W-1:0]   a_q, a_d, b_q, b_d, d_q, d_d;
  logic [C_W-1:0]   c_q, c_d;
  logic [OPM_W-1:0] opm_q, opm_d;
  logic             ci_q, ci_d;

  logic             accept;
  logic             pop;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  dsp_res_t         fifo_head;
  dsp_res_t         push_data;
  logic [OW-1:0]    pipe_cnt;
  logic [OW-1:0]    outstanding;

  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < LATENCY; i++) begin
      pipe_cnt = pipe_cnt + OW'(pipe_q[i]);
    end
  end

  assign outstanding = pipe_cnt + OW'(fifo_count);
  // live_q keeps cmd_ready low while reset is asserted and for the first edge after it.
  assign cmd_ready   = live_q && (state_q != ST_DRAIN) && (outstanding < OW'(FIFO_DEPTH));
  assign accept      = cmd_valid && cmd_ready;
  assign res_valid   = !fifo_empty;
  assign pop         = res_valid && res_ready;
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    pipe_d[0] = accept;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    d_d    = d_q;
    c_d    = c_q;
    opm_d  = opm_q;
    ci_d   = ci_q;
    live_d = 1'b1;
    if (accept) begin
      a_d   = cmd_a;
      b_d   = cmd_b;
      d_d   = cmd_d;
      c_d   = cmd_c;
      opm_d = cmd_opmode;
      ci_d  = cmd_carryin;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush)       state_d = ST_DRAIN;
        else if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush)                                 state_d = ST_DRAIN;
        else if ((outstanding == '0) && !accept)   state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if ((pipe_q == '0) && fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pipe_q  <= '0;
      live_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      c_q     <= '0;
      opm_q   <= '0;
      ci_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      live_q  <= live_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      c_q     <= c_d;
      opm_q   <= opm_d;
      ci_q    <= ci_d;
    end
  end

  // The oldest tracked op's result is on dsp_p at the edge its pipe bit leaves the top.
  assign push_data = '{p: dsp_p, carryout: dsp_carryout};

  dsp_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_q[LATENCY-1]),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign dsp_a        = a_q;
  assign dsp_b        = b_q;
  assign dsp_d        = d_q;
  assign dsp_c        = c_q;
  assign dsp_opmode   = opm_q;
  assign dsp_carryin  = ci_q;
  assign res_p        = fifo_head.p;
  assign res_carryout = fifo_head.carryout;

`ifdef DSP_SEQ_PERF_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    issued_d = issued_q + 32'(accept);
    stall_d  = stall_q + 32'(cmd_valid && !cmd_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Self-checking bench for dsp_op_sequencer with a behavioural 3-edge DSP model.
module tb_dsp_op_sequencer;

  localparam int LAT = 3;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opmode = '0;
  logic [17:0] cmd_a = '0, cmd_b = '0, cmd_d = '0;
  logic [47:0] cmd_c = '0;
  logic        cmd_carryin = 1'b0;
  logic        flush = 1'b0;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c;
  logic [7:0]  dsp_opmode;
  logic        dsp_carryin;
  logic [47:0] dsp_p;
  logic        dsp_carryout;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] res_p;
  logic        res_carryout;
  logic        busy;
`ifdef DSP_SEQ_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int acc_total = 0;
  int stall_total = 0;
  logic [48:0] exp_q[$];

  dsp_op_sequencer #(.LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opmode   (cmd_opmode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_d        (cmd_d),
    .cmd_c        (cmd_c),
    .cmd_carryin  (cmd_carryin),
    .flush        (flush),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_d        (dsp_d),
    .dsp_c        (dsp_c),
    .dsp_opmode   (dsp_opmode),
    .dsp_carryin  (dsp_carryin),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_p        (res_p),
    .res_carryout (res_carryout),
    .busy         (busy)
`ifdef DSP_SEQ_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_stall   (perf_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- DSP model: result {p,co} reaches dsp_p LAT edges after dsp_* load ----------------
  function automatic logic [48:0] dsp_f(logic [17:0] a, logic [17:0] b, logic [47:0] c,
                                        logic ci, logic [7:0] opm);
    logic [48:0] s;
    if (opm == 8'h01) begin
      s = {48'(a) * 48'(b), 1'b0};
    end else begin
      s = {1'b0, c} + 49'(a) + 49'(ci);
      s = {s[47:0], s[48]};
    end
    return s;
  endfunction

  logic [48:0] m1 = '0, m2 = '0;
  always @(posedge clk) begin
    m1 <= dsp_f(dsp_a, dsp_b, dsp_c, dsp_carryin, dsp_opmode);
    m2 <= m1;
  end
  assign dsp_p        = m2[48:1];
  assign dsp_carryout = m2[0];

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [48:0] mk(logic [47:0] p, logic co);
    return {p, co};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got %0h expected none", {res_p, res_carryout});
      end else begin
        check("result", 64'({res_p, res_carryout}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [47:0] c,
                      input logic ci, input logic [7:0] opm, input logic [48:0] exp);
    logic r;
    int   waited;
    r = 1'b0;
    waited = 0;
    cmd_a = a; cmd_b = b; cmd_d = a ^ b; cmd_c = c; cmd_carryin = ci; cmd_opmode = opm;
    cmd_valid = 1'b1;
    while (!r && waited < 200) begin
      @(negedge clk);
      r = cmd_ready;
      if (!r) stall_total++;
      @(posedge clk);
      if (r) begin
        exp_q.push_back(exp);
        acc_total++;
      end
      #1;
      waited++;
    end
    cmd_valid = 1'b0;
    if (!r) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_drain();
    int ok;
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk);
      if (!busy && !res_valid && exp_q.size() == 0) ok = 1;
    end
    @(posedge clk); #1;
    if (ok == 0) check("drain_timeout", 64'(0), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic seen;

    // Reset state
    #12;
    check("rst_dsp_a", 64'(dsp_a), 64'(0));
    check("rst_dsp_c", 64'(dsp_c), 64'(0));
    check("rst_dsp_opmode", 64'(dsp_opmode), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_cmd_ready", 64'(cmd_ready), 64'(1));

    // Single op: 6*14 = 84 visible exactly LAT edges after accept
    res_ready = 1'b1;
    send(18'd6, 18'd14, 48'd0, 1'b0, 8'h01, mk(48'd84, 1'b0));
    check("dsp_a_loaded", 64'(dsp_a), 64'(6));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_not_early", 64'(res_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_exact", 64'(res_valid), 64'(1));
    wait_drain();

    // Carry pass-through: all-ones C + 1 wraps to 0 with carry; 100+23+1 = 124
    send(18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 1'b0, 8'h02, mk(48'd0, 1'b1));
    send(18'd23, 18'd0, 48'd100, 1'b1, 8'h02, mk(48'd124, 1'b0));
    wait_drain();

    // Streaming: 8 ops, results 2,4,...,16. With LAT=3 and 4 credits the 4-op window
    // (3 in pipe + 1 in FIFO) fills once, costing exactly one stall cycle.
    base = stall_total;
    for (int i = 1; i <= 8; i++) begin
      send(18'(i), 18'd2, 48'd0, 1'b0, 8'h01, mk(48'(2 * i), 1'b0));
    end
    check("stream_stalls", 64'(stall_total - base), 64'(1));
    wait_drain();

    // Backpressure: 6 ops with res_ready=0 -> exactly 4 accepted, then release
    res_ready = 1'b0;
    base = acc_total;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(18'(10 + i), 18'd3, 48'd0, 1'b0, 8'h01, mk(48'(3 * (10 + i)), 1'b0));
        end
      end
      begin
        repeat (12) @(posedge clk);
        #2;
        check("bp_accepted", 64'(acc_total - base), 64'(4));
        check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
        res_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_all_accepted", 64'(acc_total - base), 64'(6));

    // Flush asserted together with the second accept; results held until popped
    res_ready = 1'b0;
    send(18'd5, 18'd5, 48'd0, 1'b0, 8'h01, mk(48'd25, 1'b0));
    flush = 1'b1;
    send(18'd7, 18'd3, 48'd0, 1'b0, 8'h01, mk(48'd21, 1'b0));
    flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("flush_cmd_ready", 64'(cmd_ready), 64'(0));
    check("flush_busy", 64'(busy), 64'(1));
    check("flush_res_valid", 64'(res_valid), 64'(1));
    res_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("flush_done_busy", 64'(busy), 64'(0));
    check("flush_done_ready", 64'(cmd_ready), 64'(1));
    check("flush_q_empty", 64'(exp_q.size()), 64'(0));

`ifdef DSP_SEQ_PERF_EN
    check("perf_issued", 64'(perf_issued), 64'(acc_total));
    check("perf_stall", 64'(perf_stall), 64'(stall_total));
`endif

    // Reset mid-run: two ops in flight are discarded
    send(18'd3, 18'd3, 48'd0, 1'b0, 8'h01, mk(48'd9, 1'b0));
    send(18'd4, 18'd4, 48'd0, 1'b0, 8'h01, mk(48'd16, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_dsp_a", 64'(dsp_a), 64'(0));
    check("mid_rst_dsp_b", 64'(dsp_b), 64'(0));
    check("mid_rst_opmode", 64'(dsp_opmode), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("mid_rst_res_valid", 64'(res_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("no_ghost_result", 64'(seen), 64'(0));
    check("final_q_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
